// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
//   Eight-phase fetch/execute sequencer for the 8-bit accumulator CPU.
//   A phase counter steps 0..7 once per clock. All control strobes are decoded
//   combinationally from the phase, the IR opcode, the ALU zero flag and a
//   sticky halt latch. Executing HLT freezes the phase at OP_ADDR until rst.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   opcode   in   [2:0] IR[7:5]: HLT SKZ ADD AND XOR LDA STO JMP (0..7)
//   zero     in   accumulator-is-zero flag from the ALU
//   phase    out  [2:0] current phase (registered)
//   sel      out  address mux select: 1 = PC, 0 = IR operand
//   mem_rd   out  memory read enable
//   load_ir  out  capture memory data into the IR
//   inc_pc   out  PC increment
//   load_pc  out  PC load from the IR operand
//   load_ac  out  accumulator load from the ALU output
//   mem_wr   out  memory write strobe
//   data_e   out  accumulator drives the data bus
//   halt     out  CPU halted
module ctrl_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic [2:0] phase,
  output logic       sel,
  output logic       mem_rd,
  output logic       load_ir,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_ac,
  output logic       mem_wr,
  output logic       data_e,
  output logic       halt
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_t     phase_q, phase_d;
  logic       halted_q, halted_d;
  logic [2:0] phase_inc;
  logic       alu_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  assign phase     = phase_q;
  assign phase_inc = phase_q + 3'd1;
  assign alu_op    = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);

  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    sel      = 1'b0;
    mem_rd   = 1'b0;
    load_ir  = 1'b0;
    inc_pc   = 1'b0;
    load_pc  = 1'b0;
    load_ac  = 1'b0;
    mem_wr   = 1'b0;
    data_e   = 1'b0;
    halt     = 1'b0;

    if (halted_q) begin
      // Frozen: only the halt indication is driven, inputs are ignored.
      halt = 1'b1;
    end else begin
      phase_d = phase_t'(phase_inc);
      case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel    = 1'b1;
          mem_rd = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel     = 1'b1;
          mem_rd  = 1'b1;
          load_ir = 1'b1;
        end
        OP_ADDR: begin
          if (opcode == OP_HLT) begin
            // Hold the phase here and latch halt on the next edge.
            halt     = 1'b1;
            halted_d = 1'b1;
            phase_d  = phase_q;
          end else begin
            inc_pc = 1'b1;
          end
        end
        OP_FETCH: begin
          mem_rd = alu_op;
        end
        ALU_OP: begin
          mem_rd  = alu_op;
          // SKZ skips by adding a second PC increment when the accumulator is zero.
          inc_pc  = (opcode == OP_SKZ) && zero;
          load_pc = (opcode == OP_JMP);
          data_e  = (opcode == OP_STO);
        end
        STORE: begin
          mem_rd  = alu_op;
          load_ac = alu_op;
          inc_pc  = (opcode == OP_JMP);
          load_pc = (opcode == OP_JMP);
          mem_wr  = (opcode == OP_STO);
          data_e  = (opcode == OP_STO);
        end
        default: begin
          phase_d = INST_ADDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Testbench for ctrl_sequencer: behavioural model compared every cycle, directed
// per-instruction strobe maps against literal phase masks, then random stimulus.
module tb_ctrl_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic [2:0] phase;
  logic       sel, mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, data_e, halt;

  ctrl_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .phase(phase),
    .sel(sel), .mem_rd(mem_rd), .load_ir(load_ir), .inc_pc(inc_pc),
    .load_pc(load_pc), .load_ac(load_ac), .mem_wr(mem_wr), .data_e(data_e),
    .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, ANDI = 3'd3,
                         XORI = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  // Output vector layout: {phase[2:0], sel, mem_rd, load_ir, inc_pc, load_pc,
  //                        load_ac, mem_wr, data_e, halt}
  localparam int B_SEL = 8, B_RD = 7, B_IR = 6, B_INC = 5, B_LPC = 4,
                 B_LAC = 3, B_WR = 2, B_DE = 1, B_HALT = 0;

  int         n_total = 0;
  int         n_pass  = 0;
  int         m_ph    = 0;
  bit         m_halt  = 0;
  bit         m_valid = 0;
  logic [11:0] last;
  logic [8:0]  snap [8];

  function automatic logic [11:0] model_out(int ph, bit h, logic [2:0] op, logic z);
    logic [11:0] r;
    bit aluop;
    r = '0;
    aluop = (op == ADD) || (op == ANDI) || (op == XORI) || (op == LDA);
    if (h) begin
      r[11:9]   = 3'd4;
      r[B_HALT] = 1'b1;
    end else begin
      r[11:9]   = ph[2:0];
      r[B_SEL]  = (ph <= 3);
      r[B_RD]   = (ph >= 1 && ph <= 3) || (ph >= 5 && aluop);
      r[B_IR]   = (ph == 2) || (ph == 3);
      r[B_INC]  = (ph == 4 && op != HLT) || (ph == 6 && op == SKZ && z) ||
                  (ph == 7 && op == JMP);
      r[B_LPC]  = (ph >= 6) && (op == JMP);
      r[B_LAC]  = (ph == 7) && aluop;
      r[B_WR]   = (ph == 7) && (op == STO);
      r[B_DE]   = (ph >= 6) && (op == STO);
      r[B_HALT] = (ph == 4) && (op == HLT);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic tick();
    logic [11:0] act;
    @(negedge clk);
    act  = {phase, sel, mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, data_e, halt};
    last = act;
    if (m_valid) chk("cycle_model", {20'd0, act}, {20'd0, model_out(m_ph, m_halt, opcode, zero)});
    @(posedge clk);
    if (rst) begin
      m_ph = 0; m_halt = 0; m_valid = 1;
    end else if (!m_halt) begin
      if (m_ph == 4 && opcode == HLT) m_halt = 1;
      else m_ph = (m_ph + 1) % 8;
    end
    #1;
  endtask

  function automatic logic [7:0] mask(int k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = snap[i][k];
    return r;
  endfunction

  task automatic run_instr(input logic [2:0] op, input logic z);
    rst = 1'b1; opcode = op; zero = z;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      snap[i] = last[8:0];
    end
  endtask

  initial begin
    rst = 1'b1; opcode = ADD; zero = 1'b0;
    tick();
    tick();
    chk("reset_state", {20'd0, last}, 32'h100);

    // ADD: full phase walk plus literal strobe maps.
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("add_phase", {29'd0, last[11:9]}, i % 8);
    end
    run_instr(ADD, 1'b0);
    chk("add_load_ir", mask(B_IR),  8'b0000_1100);
    chk("add_mem_rd",  mask(B_RD),  8'b1110_1110);
    chk("add_load_ac", mask(B_LAC), 8'b1000_0000);
    chk("add_mem_wr",  mask(B_WR),  8'b0000_0000);
    chk("add_sel",     mask(B_SEL), 8'b0000_1111);
    chk("add_inc_pc",  mask(B_INC), 8'b0001_0000);

    run_instr(STO, 1'b0);
    chk("sto_data_e",  mask(B_DE),  8'b1100_0000);
    chk("sto_mem_wr",  mask(B_WR),  8'b1000_0000);
    chk("sto_load_ac", mask(B_LAC), 8'b0000_0000);
    chk("sto_mem_rd",  mask(B_RD),  8'b0000_1110);

    run_instr(SKZ, 1'b1);
    chk("skz1_inc_pc", mask(B_INC), 8'b0101_0000);
    run_instr(SKZ, 1'b0);
    chk("skz0_inc_pc", mask(B_INC), 8'b0001_0000);

    run_instr(JMP, 1'b1);
    chk("jmp_load_pc", mask(B_LPC), 8'b1100_0000);
    chk("jmp_inc_pc",  mask(B_INC), 8'b1001_0000);
    chk("jmp_mem_rd",  mask(B_RD),  8'b0000_1110);

    // HLT: halt asserted in phase 4 and held; phase frozen while inputs toggle.
    run_instr(HLT, 1'b0);
    chk("hlt_halt",    mask(B_HALT), 8'b1111_0000);
    chk("hlt_inc_pc",  mask(B_INC),  8'b0000_0000);
    chk("hlt_sel",     mask(B_SEL),  8'b0000_1111);
    for (int i = 0; i < 20; i++) begin
      opcode = 3'($urandom_range(0, 7));
      zero   = 1'($urandom_range(0, 1));
      tick();
      chk("halted_hold", {20'd0, last}, 32'h801);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("halt_cleared", {20'd0, last}, 32'h100);

    // Reset landing in phase 6 of a store.
    rst = 1'b1; opcode = STO; zero = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    chk("sto_phase6_pre", {20'd0, last}, 32'hC02);
    rst = 1'b0;
    tick();
    chk("sto_rst_after", {20'd0, last}, 32'h100);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      opcode = 3'($urandom_range(0, 7));
      zero   = 1'($urandom_range(0, 1));
      rst    = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
